// File: rtl/rotary_event_pkg.sv
// Shared types and register-map constants for the rotary event queue.
package rotary_event_pkg;

  typedef struct packed {
    logic       valid;
    logic       dir;
    logic [5:0] rsvd;
    logic [7:0] pos;
    logic [15:0] ts;
  } rot_event_t;

  typedef enum logic [1:0] {
    REG_DATA   = 2'd0,
    REG_STATUS = 2'd1,
    REG_CTRL   = 2'd2,
    REG_DROPS  = 2'd3
  } reg_addr_e;

  localparam int CTRL_IRQ_EN    = 0;
  localparam int CTRL_CLR       = 1;
  localparam int CTRL_FLUSH     = 2;

  localparam int STAT_EMPTY     = 0;
  localparam int STAT_FULL      = 1;
  localparam int STAT_OVF       = 2;
  localparam int STAT_COUNT_LSB = 8;

endpackage

// File: rtl/rot_event_fifo.sv
// Synchronous event FIFO; pointers carry one extra wrap bit so full and
// empty can be told apart when the index bits match.
module rot_event_fifo
  import rotary_event_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic       pop,
  input  logic       flush,
  input  rot_event_t wdata,
  output rot_event_t rdata,
  output logic [AW:0] count,
  output logic       full,
  output logic       empty
);

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  rot_event_t  mem [DEPTH];
  logic        do_push;
  logic        do_pop;

  // A pop frees the slot the same-cycle push needs, so full only blocks a lone push.
  assign do_pop  = pop & ~empty & ~flush;
  assign do_push = push & ~flush & (~full | do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  assign rdata = mem[rd_ptr[AW-1:0]];
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count = wr_ptr - rd_ptr;

endmodule

// File: rtl/rotary_event_queue.sv
// Timestamps rotary step events into a FIFO and exposes it through a
// 4-word Avalon-MM slave (read latency 1) with a level interrupt.
module rotary_event_queue
  import rotary_event_pkg::*;
#(
  parameter int DEPTH    = 16,
  parameter int TICK_DIV = 50000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rot_cw,
  input  logic        rot_ccw,
  input  logic [7:0]  rotary_pos,
  input  logic [1:0]  avs_address,
  input  logic        avs_read,
  input  logic        avs_write,
  input  logic [31:0] avs_writedata,
  output logic [31:0] avs_readdata,
  output logic        irq
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  logic [PW-1:0] presc;
  logic [15:0]   tick;
  logic          cw_q;
  logic          ccw_q;
  logic          rise_cw;
  logic          rise_ccw;
  logic          evt_both;
  logic          evt_pending;
  rot_event_t    evt_word;
  rot_event_t    next_evt;

  rot_event_t    fifo_rdata;
  logic [AW:0]   count;
  logic          full;
  logic          empty;

  reg_addr_e     addr;
  logic          pop;
  logic          ctrl_wr;
  logic          flush;
  logic          clr;
  logic          overflow;
  logic [1:0]    drop_inc;
  logic [8:0]    drop_sum;
  logic [7:0]    drop_cnt;
  logic          ovf;
  logic          irq_en;
  logic [15:0]   count_ext;
  logic [7:0]    count8;
  logic [31:0]   status_word;
  logic          unused_wdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
      tick  <= '0;
    end else if (presc == PRESC_MAX) begin
      presc <= '0;
      tick  <= tick + 16'd1;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  assign rise_cw  = rot_cw & ~cw_q;
  assign rise_ccw = rot_ccw & ~ccw_q;
  assign evt_both = rise_cw & rise_ccw;

  always_comb begin
    next_evt       = '0;
    next_evt.valid = 1'b1;
    next_evt.dir   = rise_cw;
    next_evt.pos   = rotary_pos;
    next_evt.ts    = tick;
  end

  // The event is captured with pos/tick of the edge cycle and pushed one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cw_q        <= 1'b0;
      ccw_q       <= 1'b0;
      evt_pending <= 1'b0;
      evt_word    <= '0;
    end else begin
      cw_q        <= rot_cw;
      ccw_q       <= rot_ccw;
      evt_pending <= rise_cw ^ rise_ccw;
      evt_word    <= next_evt;
    end
  end

  rot_event_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (evt_pending),
    .pop   (pop),
    .flush (flush),
    .wdata (evt_word),
    .rdata (fifo_rdata),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  assign addr     = reg_addr_e'(avs_address);
  assign pop      = avs_read && (addr == REG_DATA) && !empty;
  assign ctrl_wr  = avs_write && (addr == REG_CTRL);
  assign flush    = ctrl_wr && avs_writedata[CTRL_FLUSH];
  assign clr      = ctrl_wr && avs_writedata[CTRL_CLR];
  assign overflow = evt_pending && full && !pop && !flush;
  assign drop_inc = {1'b0, evt_both} + {1'b0, overflow};
  assign drop_sum = {1'b0, drop_cnt} + {7'b0, drop_inc};
  assign unused_wdata = ^avs_writedata[31:3];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt <= '0;
      ovf      <= 1'b0;
      irq_en   <= 1'b0;
      irq      <= 1'b0;
    end else begin
      if (clr) begin
        drop_cnt <= '0;
        ovf      <= 1'b0;
      end else begin
        if (overflow) ovf <= 1'b1;
        drop_cnt <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
      end
      if (ctrl_wr) irq_en <= avs_writedata[CTRL_IRQ_EN];
      irq <= irq_en & ~empty;
    end
  end

  // Count is clamped to the 8-bit STATUS field; only DEPTH=256 can reach the clamp.
  assign count_ext = 16'(count);
  assign count8    = (count_ext > 16'd255) ? 8'hFF : count_ext[7:0];

  always_comb begin
    status_word                           = '0;
    status_word[STAT_EMPTY]               = empty;
    status_word[STAT_FULL]                = full;
    status_word[STAT_OVF]                 = ovf;
    status_word[STAT_COUNT_LSB +: 8]      = count8;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      avs_readdata <= '0;
    end else if (avs_read) begin
      case (addr)
        REG_DATA:   avs_readdata <= empty ? 32'd0 : fifo_rdata;
        REG_STATUS: avs_readdata <= status_word;
        REG_CTRL:   avs_readdata <= {31'd0, irq_en};
        REG_DROPS:  avs_readdata <= {24'd0, drop_cnt};
        default:    avs_readdata <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_rotary_event_queue.sv
// Randomised scenario bench for rotary_event_queue against a queue-based
// model that timestamps events from the cycle count since reset release.
module tb_rotary_event_queue;
  import rotary_event_pkg::*;

  localparam int DEPTH    = 16;
  localparam int TICK_DIV = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rot_cw = 1'b0;
  logic        rot_ccw = 1'b0;
  logic [7:0]  rotary_pos = '0;
  logic [1:0]  avs_address = '0;
  logic        avs_read = 1'b0;
  logic        avs_write = 1'b0;
  logic [31:0] avs_writedata = '0;
  logic [31:0] avs_readdata;
  logic        irq;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  logic [31:0] q[$];
  int          m_drops;
  bit          m_ovf;
  bit          m_prev_cw;
  bit          m_prev_ccw;

  rotary_event_queue #(.DEPTH(DEPTH), .TICK_DIV(TICK_DIV)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .rot_cw        (rot_cw),
    .rot_ccw       (rot_ccw),
    .rotary_pos    (rotary_pos),
    .avs_address   (avs_address),
    .avs_read      (avs_read),
    .avs_write     (avs_write),
    .avs_writedata (avs_writedata),
    .avs_readdata  (avs_readdata),
    .irq           (irq)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic tick_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    q.delete();
    m_drops = 0;
    m_ovf = 0;
    m_prev_cw = 0;
    m_prev_ccw = 0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    avs_read = 1'b0;
    avs_write = 1'b0;
    rot_cw = 1'b0;
    rot_ccw = 1'b0;
    tick_clk(2);
    rst_n = 1'b1;
    model_reset();
  endtask

  // Drives the decoder levels for the current cycle and records the resulting event.
  task automatic set_rot(input bit cw, input bit ccw, input logic [7:0] pos);
    bit rc;
    bit rcc;
    logic [31:0] w;
    rc = cw & ~m_prev_cw;
    rcc = ccw & ~m_prev_ccw;
    if (rc ^ rcc) begin
      w = {1'b1, rc, 6'b0, pos, 16'((cyc / TICK_DIV) % 65536)};
      if (q.size() < DEPTH) q.push_back(w);
      else begin
        m_ovf = 1;
        if (m_drops < 255) m_drops++;
      end
    end else if (rc & rcc) begin
      if (m_drops < 255) m_drops++;
    end
    m_prev_cw = cw;
    m_prev_ccw = ccw;
    rot_cw = cw;
    rot_ccw = ccw;
    rotary_pos = pos;
  endtask

  function automatic logic [31:0] model_pop();
    if (q.size() == 0) return 32'd0;
    return q.pop_front();
  endfunction

  function automatic logic [31:0] exp_status();
    logic [31:0] s;
    s = '0;
    s[0] = (q.size() == 0);
    s[1] = (q.size() == DEPTH);
    s[2] = m_ovf;
    s[15:8] = 8'(q.size());
    return s;
  endfunction

  task automatic do_read(input logic [1:0] addr, output logic [31:0] data);
    avs_address = addr;
    avs_read = 1'b1;
    tick_clk(1);
    avs_read = 1'b0;
    data = avs_readdata;
  endtask

  task automatic do_write(input logic [1:0] addr, input logic [31:0] data);
    avs_address = addr;
    avs_writedata = data;
    avs_write = 1'b1;
    tick_clk(1);
    avs_write = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    apply_reset();
    total++;
    if (avs_readdata !== 32'd0 || irq !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_outputs: got rd=%h irq=%b want rd=0 irq=0", avs_readdata, irq);
    end
    do_read(REG_STATUS, d);
    total++;
    if (d !== 32'h1) begin bad++; $display("[TB] FAIL reset_status: got %h want %h", d, 32'h1); end
    do_read(REG_CTRL, d);
    total++;
    if (d !== 32'h0) begin bad++; $display("[TB] FAIL reset_ctrl: got %h want 0", d); end
    do_read(REG_DROPS, d);
    total++;
    if (d !== 32'h0) begin bad++; $display("[TB] FAIL reset_drops: got %h want 0", d); end
    do_read(REG_DATA, d);
    total++;
    if (d !== 32'h0) begin bad++; $display("[TB] FAIL reset_data_empty: got %h want 0", d); end
  endtask

  task automatic test_single_event();
    logic [31:0] d;
    logic [31:0] exp;
    apply_reset();
    tick_clk(10);
    set_rot(1, 0, 8'h05);
    tick_clk(1);
    set_rot(0, 0, 8'h05);
    do_read(REG_STATUS, d);
    total++;
    if (d !== 32'h1) begin bad++; $display("[TB] FAIL single_status_n1: got %h want %h", d, 32'h1); end
    do_read(REG_STATUS, d);
    exp = exp_status();
    total++;
    if (d !== exp) begin bad++; $display("[TB] FAIL single_status_n2: got %h want %h", d, exp); end
    do_read(REG_DATA, d);
    exp = model_pop();
    total++;
    if (d !== 32'hC005_0002 || d !== exp) begin
      bad++;
      $display("[TB] FAIL single_data: got %h want %h", d, 32'hC005_0002);
    end
    do_read(REG_DATA, d);
    total++;
    if (d !== 32'h0) begin bad++; $display("[TB] FAIL single_data_empty: got %h want 0", d); end
  endtask

  task automatic test_direction_irq();
    logic [31:0] d;
    logic [31:0] exp;
    apply_reset();
    do_write(REG_CTRL, 32'h1);
    tick_clk($urandom_range(0, 5));
    set_rot(0, 1, 8'hFF);
    tick_clk(1);
    set_rot(0, 0, 8'hFF);
    tick_clk(1);
    total++;
    if (irq !== 1'b0) begin bad++; $display("[TB] FAIL irq_n2: got %b want 0", irq); end
    tick_clk(1);
    total++;
    if (irq !== 1'b1) begin bad++; $display("[TB] FAIL irq_n3: got %b want 1", irq); end
    do_read(REG_DATA, d);
    exp = model_pop();
    total++;
    if (d[31:16] !== 16'h80FF || d !== exp) begin
      bad++;
      $display("[TB] FAIL ccw_data: got %h want %h", d, exp);
    end
    total++;
    if (irq !== 1'b1) begin bad++; $display("[TB] FAIL irq_pop_r1: got %b want 1", irq); end
    tick_clk(1);
    total++;
    if (irq !== 1'b0) begin bad++; $display("[TB] FAIL irq_pop_r2: got %b want 0", irq); end
    do_read(REG_CTRL, d);
    total++;
    if (d !== 32'h1) begin bad++; $display("[TB] FAIL ctrl_readback: got %h want 1", d); end
  endtask

  task automatic test_overflow();
    logic [31:0] d;
    logic [31:0] exp;
    logic [7:0]  pos;
    bit          dir;
    apply_reset();
    for (int i = 0; i < DEPTH + 2; i++) begin
      pos = 8'($urandom);
      dir = 1'($urandom);
      set_rot(dir, !dir, pos);
      tick_clk(1);
      set_rot(0, 0, pos);
      tick_clk(1 + $urandom_range(0, 2));
    end
    do_read(REG_STATUS, d);
    exp = exp_status();
    total++;
    if (d !== exp || d !== 32'h1006) begin bad++; $display("[TB] FAIL ovf_status: got %h want %h", d, exp); end
    do_read(REG_DROPS, d);
    total++;
    if (d !== 32'(m_drops) || d !== 32'd2) begin bad++; $display("[TB] FAIL ovf_drops: got %h want %h", d, 32'(m_drops)); end
    avs_address = REG_DATA;
    avs_read = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      exp = model_pop();
      tick_clk(1);
      if (i == DEPTH - 1) avs_read = 1'b0;
      d = avs_readdata;
      total++;
      if (d !== exp) begin bad++; $display("[TB] FAIL ovf_drain[%0d]: got %h want %h", i, d, exp); end
    end
    do_write(REG_CTRL, 32'h2);
    m_ovf = 0;
    m_drops = 0;
    do_read(REG_STATUS, d);
    exp = exp_status();
    total++;
    if (d !== exp) begin bad++; $display("[TB] FAIL ovf_clear_status: got %h want %h", d, exp); end
    do_read(REG_DROPS, d);
    total++;
    if (d !== 32'd0) begin bad++; $display("[TB] FAIL ovf_clear_drops: got %h want 0", d); end
  endtask

  task automatic test_full_push_pop();
    logic [31:0] d;
    logic [31:0] exp;
    logic [7:0]  pos;
    apply_reset();
    for (int i = 0; i < DEPTH; i++) begin
      pos = 8'($urandom);
      set_rot(1, 0, pos);
      tick_clk(1);
      set_rot(0, 0, pos);
      tick_clk(1);
    end
    // The pop and the push commit together, so the model pops first to make room.
    exp = model_pop();
    pos = 8'($urandom);
    set_rot(1, 0, pos);
    tick_clk(1);
    set_rot(0, 0, pos);
    do_read(REG_DATA, d);
    total++;
    if (d !== exp) begin bad++; $display("[TB] FAIL fpp_head: got %h want %h", d, exp); end
    do_read(REG_STATUS, d);
    exp = exp_status();
    total++;
    if (d !== exp || d !== 32'h1002) begin bad++; $display("[TB] FAIL fpp_status: got %h want %h", d, exp); end
    avs_address = REG_DATA;
    avs_read = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      exp = model_pop();
      tick_clk(1);
      if (i == DEPTH - 1) avs_read = 1'b0;
      d = avs_readdata;
      total++;
      if (d !== exp) begin bad++; $display("[TB] FAIL fpp_drain[%0d]: got %h want %h", i, d, exp); end
    end
    total++;
    if (d[23:16] !== pos) begin bad++; $display("[TB] FAIL fpp_last_pos: got %h want %h", d[23:16], pos); end
  endtask

  task automatic test_simul_flush();
    logic [31:0] d;
    logic [31:0] exp;
    logic [7:0]  pos;
    apply_reset();
    pos = 8'($urandom);
    set_rot(1, 1, pos);
    tick_clk(1);
    set_rot(0, 0, pos);
    tick_clk(2);
    do_read(REG_STATUS, d);
    exp = exp_status();
    total++;
    if (d !== exp || d !== 32'h1) begin bad++; $display("[TB] FAIL simul_status: got %h want %h", d, exp); end
    do_read(REG_DROPS, d);
    total++;
    if (d !== 32'd1) begin bad++; $display("[TB] FAIL simul_drops: got %h want 1", d); end
    for (int i = 0; i < 5; i++) begin
      pos = 8'($urandom);
      set_rot(i % 2 == 0, i % 2 == 1, pos);
      tick_clk(1);
      set_rot(0, 0, pos);
      tick_clk(1 + $urandom_range(0, 1));
    end
    do_read(REG_STATUS, d);
    exp = exp_status();
    total++;
    if (d !== exp || d[15:8] !== 8'd5) begin bad++; $display("[TB] FAIL flush_pre_status: got %h want %h", d, exp); end
    do_write(REG_CTRL, 32'h4);
    q.delete();
    do_read(REG_STATUS, d);
    exp = exp_status();
    total++;
    if (d !== exp || d !== 32'h1) begin bad++; $display("[TB] FAIL flush_status: got %h want %h", d, exp); end
  endtask

  task automatic test_reset_midstream();
    logic [31:0] d;
    logic [31:0] exp;
    logic [7:0]  pos;
    apply_reset();
    do_write(REG_CTRL, 32'h1);
    for (int i = 0; i < 3; i++) begin
      pos = 8'($urandom_range(1, 255));
      set_rot(1, 0, pos);
      tick_clk(1);
      set_rot(0, 0, pos);
      tick_clk(1);
    end
    tick_clk(2);
    total++;
    if (irq !== 1'b1) begin bad++; $display("[TB] FAIL mid_irq_pre: got %b want 1", irq); end
    do_read(REG_DATA, d);
    exp = model_pop();
    total++;
    if (d !== exp) begin bad++; $display("[TB] FAIL mid_data_pre: got %h want %h", d, exp); end
    avs_address = REG_DATA;
    avs_read = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (irq !== 1'b0 || avs_readdata !== 32'd0) begin
      bad++;
      $display("[TB] FAIL mid_reset_outputs: got irq=%b rd=%h want irq=0 rd=0", irq, avs_readdata);
    end
    avs_read = 1'b0;
    tick_clk(2);
    rst_n = 1'b1;
    model_reset();
    do_read(REG_STATUS, d);
    total++;
    if (d !== 32'h1) begin bad++; $display("[TB] FAIL mid_status_post: got %h want %h", d, 32'h1); end
    tick_clk($urandom_range(0, 9));
    pos = 8'($urandom);
    set_rot(0, 1, pos);
    tick_clk(1);
    set_rot(0, 0, pos);
    tick_clk(2);
    do_read(REG_DATA, d);
    exp = model_pop();
    total++;
    if (d !== exp) begin bad++; $display("[TB] FAIL mid_tick_restart: got %h want %h", d, exp); end
  endtask

  initial begin
    test_reset();
    test_single_event();
    test_direction_irq();
    test_overflow();
    test_full_push_pop();
    test_simul_flush();
    test_reset_midstream();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rotary_event_queue.md
# rotary_event_queue

Downstream consumer of the rotary decoder: detects each step event on the decoder's `rot_cw`/`rot_ccw` level outputs, timestamps it, and stores it with the current `rotary_pos` in a FIFO. The FIFO is exposed to the Nios/Qsys system through a 4-word Avalon-MM slave with fixed read latency 1. An interrupt is raised while events are pending. The queue lets software recover every step, including fast spins between polls, and reports overflow explicitly.

## Interface
- `DEPTH`, 16: FIFO entries; power of two, 2..256.
- `TICK_DIV`, 50000: clk cycles per timestamp tick (1 ms at 50 MHz); ≥1.
- `clk` in 1: system clock.
- `rst_n` in 1: reset, asynchronous assert, active-low (one clock; async active-low reset fixed).
- `rot_cw` in 1: decoder CW level; its rising edge marks a CW step.
- `rot_ccw` in 1: decoder CCW level; its rising edge marks a CCW step.
- `rotary_pos` in 8: decoder position, already updated in the cycle the edge appears.
- `avs_address` in 2: word address.
- `avs_read` in 1: read strobe.
- `avs_write` in 1: write strobe.
- `avs_writedata` in 32: write data.
- `avs_readdata` out 32: read data, valid exactly 1 cycle after `avs_read`.
- `irq` out 1: level interrupt.

## Operation
- **Edge detection:** registered previous copies of `rot_cw`/`rot_ccw`.
  - A rising edge on exactly one input is an event; dir=1 for CW.
  - Rising edges on both inputs in the same cycle: no push; `drop_cnt` increments.
- **Timestamp:**
  - A prescaler counts 0..TICK_DIV-1.
  - On wrap, the 16-bit `tick` increments. `tick` wraps 0xFFFF→0 silently.
- **Event word:**
  - bit31 valid=1.
  - bit30 dir.
  - bits29:24 zero.
  - bits23:16 `rotary_pos` sampled in the edge cycle.
  - bits15:0 `tick`.
- **Push to a full FIFO:**
  - Event discarded, sticky `ovf` set, `drop_cnt` increments.
  - Exception: a pop in the same cycle. Then the push is accepted and there is no overflow.
- **`drop_cnt`:** 8 bits, saturates at 255.
- **Register map (word addresses):**
  - 0 DATA (R): pops the head entry; a read when empty returns 0 (valid=0), no pop.
  - 1 STATUS (R): bit0 empty, bit1 full, bit2 ovf, bits15:8 count (0..DEPTH).
  - 2 CTRL (R/W):
    - bit0 irq_en (RW).
    - bit1 write-1 clears ovf and `drop_cnt`.
    - bit2 write-1 flushes the FIFO. Flush wins over a same-cycle push.
    - Bits 1 and 2 read 0.
  - 3 DROPS (R): `drop_cnt` zero-extended.
- **Side effects:** only a DATA read pops. Writes to addresses 0, 1 and 3 are ignored. Simultaneous `avs_read` and `avs_write` are both serviced.
- **`irq`:** registered, = irq_en & !empty.
- **Reset:**
  - All state cleared: FIFO empty, pointers 0, ovf 0, `drop_cnt` 0, irq_en 0, prescaler 0, `tick` 0, edge registers 0.
  - `avs_readdata` = 0, `irq` = 0.
  - Reset mid-read aborts the response; no readdata obligation.

## Timing
- An edge on input in cycle N is visible in the count/empty flags at cycle N+2: edge register, then push.
- `irq` rises at N+3.
- A read in cycle R:
  - Pop is committed at the end of R.
  - `avs_readdata` is valid in R+1.
  - STATUS read in R+1 shows the decremented count.
- Back-to-back DATA reads every cycle return successive entries.
- Push and pop in the same cycle: count unchanged. Count never exceeds DEPTH and never goes negative.
- `rot_cw` and `rot_ccw` are synchronous to `clk`; they are already debounced upstream, so no resynchronisation is applied here.

## Structure
- Package `rotary_event_pkg` holds:
  - `rot_event_t` packed struct (valid, dir, rsvd[5:0], pos[7:0], ts[15:0]).
  - `reg_addr_e` enum (DATA, STATUS, CTRL, DROPS).
  - CTRL/STATUS bit-index localparams.
- Sub-module `rot_event_fifo`:
  - Synchronous FIFO, DEPTH×32.
  - Pointers are $clog2(DEPTH)+1 bits, with full/empty derived from the MSB compare.
  - Ports: push, pop, flush, wdata, rdata, count, full, empty.
- Top level holds the edge detect, prescaler/tick, `drop_cnt`, register decode and read mux.

## Test plan
- **Single event, read back:** after reset with TICK_DIV=4, pulse `rot_cw` 0→1 with pos=0x05 after 10 cycles → STATUS count=1; DATA read returns 0xC005_0002 (valid, CW, pos 5, tick 2); next DATA read returns 0.
- **Direction and irq:** set CTRL=1, pulse `rot_ccw` with pos=0xFF → `irq` high 3 cycles after the edge; DATA returns 0x80FF_xxxx; `irq` low one cycle after the pop.
- **Overflow:** DEPTH=16, 18 CW edges without reads → STATUS full=1, ovf=1, count=16; DROPS=2; the 16 DATA reads return pos in order; write CTRL=0x2 → ovf=0, DROPS=0.
- **Full push and pop same cycle:** FIFO full, DATA read coincides with a push → count stays 16, ovf stays 0, the last entry holds the new pos.
- **Simultaneous edges and flush:** rising edges on `rot_cw` and `rot_ccw` in the same cycle → no entry, DROPS=1; CTRL=0x4 with 5 entries queued → STATUS empty=1, count=0.
- **Reset mid-stream:** deassert `rst_n` asynchronously with entries queued and a read in flight → `irq`=0 and readdata=0 immediately; after release STATUS=0x1 and `tick` restarts at 0.
